// File: rtl/fill_arbiter.sv
// Round-robin line-fill arbiter sharing one backing store between the icache and dcache miss paths.
// A granted request holds its line address on the store for MEM_LATENCY cycles, then returns the line.
module fill_arbiter #(
  parameter int LINE_WORDS  = 32,
  parameter int MEM_LATENCY = 8,
  parameter int OFF_BITS    = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_req,
  input  logic [31:0]                i_addr,
  output logic                       i_valid,
  input  logic                       d_req,
  input  logic [31:0]                d_addr,
  output logic                       d_valid,
  output logic [32*LINE_WORDS-1:0]   line_data,
  output logic [31:0]                mem_addr,
  input  logic [32*LINE_WORDS-1:0]   mem_line,
  output logic                       busy
);

  localparam int         LINE_W   = 32 * LINE_WORDS;
  localparam logic [7:0] CNT_LAST = 8'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic       {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_q,  last_d;
  logic [7:0]          cnt_q,   cnt_d;
  logic [31:0]         addr_q,  addr_d;
  logic [LINE_W-1:0]   line_q,  line_d;
  owner_e              grant_w;

  function automatic logic [31:0] line_align(input logic [31:0] a);
    return a & ~((32'd1 << OFF_BITS) - 32'd1);
  endfunction

  // On a tie the side that did not win last time is chosen, so contention alternates.
  always_comb begin
    grant_w = OWN_I;
    if (i_req && d_req) begin
      grant_w = (last_q == OWN_I) ? OWN_D : OWN_I;
    end else if (d_req) begin
      grant_w = OWN_D;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = WAIT;
          owner_d = grant_w;
          last_d  = grant_w;
          cnt_d   = '0;
          addr_d  = line_align((grant_w == OWN_D) ? d_addr : i_addr);
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          line_d  = mem_line;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset also clears the datapath so an aborted fill leaves no stale line or address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_D;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  assign i_valid   = (state_q == RESP) && (owner_q == OWN_I);
  assign d_valid   = (state_q == RESP) && (owner_q == OWN_D);
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign line_data = line_q;

  a_valid_onehot: assert property (@(posedge clk) disable iff (reset) !(i_valid && d_valid));

endmodule

// File: tb/tb_fill_arbiter.sv
// Bench for fill_arbiter: directed scenarios plus randomized requesters, checked every cycle
// against a countdown-based transaction model of the arbiter.
module tb_fill_arbiter;
  localparam int LINE_WORDS  = 32;
  localparam int MEM_LATENCY = 8;
  localparam int OFF_BITS    = 7;
  localparam int LW          = 32 * LINE_WORDS;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req;
  logic [31:0]   i_addr, d_addr, mem_addr;
  logic          i_valid, d_valid, busy;
  logic [LW-1:0] line_data, mem_line;

  logic [1:0]    rq;
  logic [31:0]   ra [2];
  int            st [2];
  bit            vis [2];
  bit            rnd_en, reassert_en;

  int            checks, errors, cyc;
  int            m_rem;
  bit            m_own_d, m_last_d;
  logic [31:0]   m_addr;
  logic [LW-1:0] m_line;
  int            ival[$], dval[$], vlog[$];

  assign i_req  = rq[0];
  assign d_req  = rq[1];
  assign i_addr = ra[0];
  assign d_addr = ra[1];

  fill_arbiter #(.LINE_WORDS(LINE_WORDS), .MEM_LATENCY(MEM_LATENCY), .OFF_BITS(OFF_BITS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid),
    .d_req(d_req), .d_addr(d_addr), .d_valid(d_valid),
    .line_data(line_data), .mem_addr(mem_addr), .mem_line(mem_line), .busy(busy)
  );

  always #5 clk = ~clk;

  // Backing-store model: every word is a distinct function of the line address and its index.
  function automatic logic [LW-1:0] store_line(input logic [31:0] a);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < LINE_WORDS; k++)
      l[LW-1-32*k -: 32] = (a ^ (32'(k) * 32'h9E37_79B9)) + 32'(k);
    return l;
  endfunction

  always_comb mem_line = store_line(mem_addr);

  task automatic check_eq(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h (low 128b)", tag, cyc, act[127:0], exp[127:0]);
    end
  endtask

  // One clock: model update at the edge, output check just after it, stimulus at the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_rem = 0; m_last_d = 1'b1; m_addr = '0; m_line = '0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 1) m_line = store_line(m_addr);
    end else if (i_req || d_req) begin
      m_own_d  = (i_req && d_req) ? !m_last_d : d_req;
      m_last_d = m_own_d;
      m_addr   = (m_own_d ? d_addr : i_addr) & ~((32'd1 << OFF_BITS) - 32'd1);
      m_rem    = MEM_LATENCY + 1;
    end
    #1;
    check_eq("busy",      busy,      m_rem > 0);
    check_eq("i_valid",   i_valid,   m_rem == 1 && !m_own_d);
    check_eq("d_valid",   d_valid,   m_rem == 1 && m_own_d);
    check_eq("mem_addr",  mem_addr,  m_addr);
    check_eq("line_data", line_data, m_line);
    vis[0] = (m_rem == 1) && !m_own_d;
    vis[1] = (m_rem == 1) && m_own_d;
    if (i_valid) begin ival.push_back(cyc); vlog.push_back(0); end
    if (d_valid) begin dval.push_back(cyc); vlog.push_back(1); end
    @(negedge clk);
    if (rnd_en) begin
      reset = ($urandom_range(0, 250) == 0);
      if (reset) begin rq = '0; st[0] = 0; st[1] = 0; end
    end
    for (int s = 0; s < 2; s++) begin
      case (st[s])
        0: if ((rnd_en && !reset && $urandom_range(0, 3) == 0) || reassert_en) begin
             st[s] = 1; rq[s] = 1'b1; ra[s] = $urandom;
           end
        1: if (vis[s]) begin
             st[s] = 0; rq[s] = 1'b0;
           end else if (rnd_en) begin
             if ($urandom_range(0, 15) == 0) ra[s] = $urandom;
             if (m_rem > 1 && int'(m_own_d) == s && $urandom_range(0, 40) == 0) begin
               st[s] = 2; rq[s] = 1'b0;
             end
           end
        2: if (vis[s]) st[s] = 0;
        default: st[s] = 0;
      endcase
    end
  endtask

  task automatic settle(input int max);
    int n = 0;
    while ((m_rem > 0 || rq != 2'b00) && n < max) begin step(); n++; end
    check_eq("settle_in_budget", n < max, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1; rq = '0; st[0] = 0; st[1] = 0;
    step(); step();
    reset = 1'b0;
    ival.delete(); dval.delete(); vlog.delete();
  endtask

  initial begin
    int e0, n;
    checks = 0; errors = 0; cyc = 0;
    m_rem = 0; m_own_d = 1'b0; m_last_d = 1'b1; m_addr = '0; m_line = '0;
    rq = '0; ra[0] = '0; ra[1] = '0; st[0] = 0; st[1] = 0;
    rnd_en = 1'b0; reassert_en = 1'b0; reset = 1'b1;

    // Reset then idle
    do_reset();
    repeat (20) step();
    check_eq("idle_no_valid", ival.size() + dval.size(), 0);

    // Single icache fill
    rq[0] = 1'b1; ra[0] = 32'h0000_10A4; st[0] = 1;
    step(); e0 = cyc;
    check_eq("t2_addr", mem_addr, 32'h0000_1080);
    check_eq("t2_busy", busy, 1'b1);
    settle(30);
    check_eq("t2_nval", ival.size(), 1);
    if (ival.size() > 0) check_eq("t2_vcyc", ival[0], e0 + MEM_LATENCY);
    check_eq("t2_line", line_data, store_line(32'h0000_1080));

    // Simultaneous requests after reset: icache first
    do_reset();
    rq = 2'b11; ra[0] = 32'h0000_5A5C; ra[1] = 32'h0000_2000; st[0] = 1; st[1] = 1;
    settle(60);
    check_eq("t3_nval", vlog.size(), 2);
    if (vlog.size() == 2) begin
      check_eq("t3_first_i", vlog[0], 0);
      check_eq("t3_gap", dval[0] - ival[0], 10);
    end
    check_eq("t3_dline", line_data, store_line(32'h0000_2000));

    // Continuous contention
    do_reset();
    reassert_en = 1'b1;
    rq = 2'b11; ra[0] = $urandom; ra[1] = $urandom; st[0] = 1; st[1] = 1;
    n = 0;
    while (vlog.size() < 4 && n < 100) begin step(); n++; end
    reassert_en = 1'b0;
    check_eq("t4_fills", vlog.size() >= 4, 1'b1);
    if (vlog.size() >= 4)
      for (int k = 0; k < 4; k++) check_eq("t4_order", vlog[k], k % 2);
    settle(80);

    // dcache request withdrawn at cnt==3
    do_reset();
    rq[1] = 1'b1; ra[1] = 32'h0000_3F10; st[1] = 1;
    step(); e0 = cyc;
    repeat (3) step();
    rq[1] = 1'b0; st[1] = 2;
    settle(30);
    repeat (10) step();
    check_eq("t5_nval", dval.size(), 1);
    if (dval.size() > 0) check_eq("t5_vcyc", dval[0], e0 + MEM_LATENCY);
    check_eq("t5_idle", busy, 1'b0);

    // Reset during WAIT at cnt==4
    do_reset();
    rq[0] = 1'b1; ra[0] = 32'h0000_7777; st[0] = 1;
    step();
    repeat (4) step();
    reset = 1'b1; rq = '0; st[0] = 0;
    step();
    check_eq("t6_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (12) step();
    check_eq("t6_noval", ival.size(), 0);
    rq[0] = 1'b1; ra[0] = 32'h0000_0145; st[0] = 1;
    step(); e0 = cyc;
    settle(30);
    check_eq("t6_nval", ival.size(), 1);
    if (ival.size() > 0) check_eq("t6_vcyc", ival[0], e0 + MEM_LATENCY);

    // Randomized traffic with address wobble, withdrawals and occasional resets
    do_reset();
    rnd_en = 1'b1;
    repeat (3000) step();
    rnd_en = 1'b0; reset = 1'b0;
    settle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fill_arbiter.md
Name: fill_arbiter

Overview:
- Shares the single backing store (the hard-disk line model) between the instruction-cache and data-cache miss paths.
- Accepts level-held line-fill requests from both caches and grants them round-robin.
- Holds the granted line address stable on the store for a fixed access latency, then captures the full 32-word line and returns it to the granted requester with a one-cycle valid pulse.
- Sits between icache/dcache and the store; the caches no longer instantiate the store directly.

Parameters:
- LINE_WORDS, 32, number of 32-bit words per cache line (line data width = 32*LINE_WORDS).
- MEM_LATENCY, 8, cycles the address is held on the store before the line is captured; legal range 1..255.
- OFF_BITS, 7, byte-offset bits forced to zero in the issued line address (log2(LINE_WORDS*4)).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- i_req  input  1  icache fill request; held high until i_valid seen
- i_addr  input  32  icache miss address (any byte within line)
- i_valid  output  1  one-cycle pulse: line_data holds icache's line
- d_req  input  1  dcache fill request; held high until d_valid seen
- d_addr  input  32  dcache miss address
- d_valid  output  1  one-cycle pulse: line_data holds dcache's line
- line_data  output  32*LINE_WORDS  captured line, word 0 in most-significant slot
- mem_addr  output  32  line-aligned address driven to the store
- mem_line  input  32*LINE_WORDS  store's combinational line read of mem_addr
- busy  output  1  high whenever state is not IDLE

Behaviour:
- One clock, clk; reset synchronous, active-high. All state updates on posedge clk.
- Reset values: state=IDLE, cnt=0, last_grant=D (so icache wins first tie), i_valid=0, d_valid=0, line_data=0, mem_addr=0, busy=0. Reset mid-fill aborts immediately; no valid pulse is issued for the aborted fill.
- States: IDLE, WAIT, RESP.
- IDLE: if neither req is high, stay. If exactly one is high, grant it. If both are high, grant the requester not equal to last_grant.
- On grant: latch owner, latch mem_addr = req address with its OFF_BITS least-significant bits zeroed, set cnt=0, set last_grant=owner, go to WAIT.
- WAIT: mem_addr held constant. Each edge cnt increments. On the edge where cnt==MEM_LATENCY-1: line_data<=mem_line, go to RESP.
- RESP: owner's valid=1 for exactly this cycle; the other valid stays 0. Next edge goes to IDLE; line_data holds its value until the next capture.
- Latency: valid is high in the cycle following the MEM_LATENCY-th edge after the granting edge. The full turnaround is MEM_LATENCY+2 cycles of occupancy.
- Requester rule: the requester drops req at the edge that ends its valid cycle. Req is therefore sampled low in the following IDLE cycle, and no duplicate fill occurs.
- Req dropped during WAIT: the fill still completes and valid still pulses; the requester ignores it. Other-side requests arriving during WAIT/RESP are held pending and served from IDLE.
- Address changes during WAIT have no effect; only the latched address is used.
- i_valid and d_valid are never high simultaneously.
- No back-to-back starvation: with both reqs continuously high, grants alternate I, D, I, D.

Test Plan:
- Reset then idle: reset high 2 cycles, no reqs -> busy=0, i_valid=d_valid=0, mem_addr=0 for 20 cycles.
- Single icache fill, MEM_LATENCY=8: i_req=1, i_addr=0x0000_10A4 sampled at edge E0 -> mem_addr=0x0000_1080 from E0 to E8; line_data=store line at 0x1080; i_valid high only in the cycle after E8; busy high from E0 through that cycle.
- Simultaneous requests after reset: i_req=d_req=1, d_addr=0x0000_2000 -> icache served first; then d_valid with the line at 0x2000 follows, d_valid rising 10 cycles after i_valid.
- Continuous contention: both reqs re-asserted immediately after each valid for 4 fills -> grant order I, D, I, D; valids never overlap.
- Request withdrawn mid-fill: d_req dropped at cnt==3 -> d_valid still pulses once at the expected cycle; no new fill starts afterward.
- Reset mid-WAIT: reset at cnt==4 -> next cycle state IDLE, busy=0, no valid pulse; a fresh i_req afterward completes with the normal MEM_LATENCY timing.
